// File: rtl/level_column_loader.sv
`default_nettype none
// ============================================================================
// Module   : level_column_loader
// Purpose  : Feeds the on-screen block grid from the synchronous level ROM.
//            Supports a full-screen load (COLS columns x ROWS rows) and a
//            single-column load when the camera scrolls one tile right. The
//            grid is a circular buffer of columns; o_head_slot names the slot
//            holding the leftmost visible level column (o_scroll_col).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk             in   1   system clock
//   Reset           in   1   synchronous, active-high reset
//   i_load_start    in   1   pulse: full-screen load from level column i_start_col
//   i_start_col     in   8   first level column for a full load (clamped)
//   i_scroll_step   in   1   pulse: load the next column on the right
//   o_rom_addr      out  12  level ROM address {level_col[7:0], row[3:0]}
//   i_rom_data      in   4   ROM block ID, valid the cycle after o_rom_addr
//   o_grid_row      out  4   target tile row
//   o_grid_col      out  5   target tile slot (0..COLS-1)
//   o_new_block_id  out  4   block ID to write
//   o_change_id     out  1   one-cycle write strobe for (o_grid_row, o_grid_col)
//   o_head_slot     out  5   grid slot holding the leftmost visible column
//   o_scroll_col    out  8   level column shown in o_head_slot
//   o_busy          out  1   high whenever an operation is in progress
//   o_done          out  1   one-cycle pulse when an operation completes
//   o_at_end        out  1   o_scroll_col + COLS >= LEVEL_COLS
//   o_scroll_drop   out  1   one-cycle pulse when a scroll step is discarded
// ============================================================================
module level_column_loader #(
  parameter int ROWS       = 15,
  parameter int COLS       = 20,
  parameter int LEVEL_COLS = 224
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_load_start,
  input  logic [7:0]  i_start_col,
  input  logic        i_scroll_step,
  output logic [11:0] o_rom_addr,
  input  logic [3:0]  i_rom_data,
  output logic [3:0]  o_grid_row,
  output logic [4:0]  o_grid_col,
  output logic [3:0]  o_new_block_id,
  output logic        o_change_id,
  output logic [4:0]  o_head_slot,
  output logic [7:0]  o_scroll_col,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_at_end,
  output logic        o_scroll_drop
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_READ  = 3'd2;
  localparam logic [2:0] c_WRITE = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [3:0] c_LAST_ROW  = 4'(ROWS - 1);
  localparam logic [4:0] c_LAST_SLOT = 5'(COLS - 1);
  localparam logic [7:0] c_COLS8     = 8'(COLS);
  localparam logic [7:0] c_MAX_START = 8'(LEVEL_COLS - COLS);
  localparam logic [8:0] c_COLS9     = 9'(COLS);
  localparam logic [8:0] c_LEVEL9    = 9'(LEVEL_COLS);

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [2:0]  r_state;
  logic [2:0]  w_state_next;

  logic [3:0]  r_row;          // row of the tile in flight
  logic [4:0]  r_slot;         // grid slot of the tile in flight
  logic [7:0]  r_col;          // level column of the tile in flight
  logic        r_mode_scroll;  // 1: single-column load, 0: full-screen load
  logic        r_pending;      // one scroll step queued behind the current op

  logic [11:0] r_rom_addr;
  logic [3:0]  r_grid_row;
  logic [4:0]  r_grid_col;
  logic [3:0]  r_block_id;
  logic [4:0]  r_head_slot;
  logic [7:0]  r_scroll_col;
  logic        r_scroll_drop;

  logic        w_change_id;
  logic        w_busy;
  logic        w_done;

  logic        w_at_end;
  logic        w_start_scroll;
  logic        w_last_tile;
  logic [7:0]  w_c0;
  logic [7:0]  w_scroll_load_col;

  // Evaluated in 9 bits so LEVEL_COLS up to 256 compares correctly.
  assign w_at_end = ({1'b0, r_scroll_col} + c_COLS9) >= c_LEVEL9;

  // Clamp so the whole screen stays inside the level; this also keeps every
  // later column sum within 8 bits.
  assign w_c0 = (i_start_col > c_MAX_START) ? c_MAX_START : i_start_col;

  assign w_scroll_load_col = r_scroll_col + c_COLS8;

  // A queued step is serviced ahead of a fresh one; either is refused at the
  // right-hand end of the level. load_start always takes priority.
  assign w_start_scroll = (r_state == c_IDLE) && !i_load_start &&
                          (r_pending || i_scroll_step) && !w_at_end;

  // Scroll loads finish after one column; full loads after the last slot.
  assign w_last_tile = (r_row == c_LAST_ROW) &&
                       (r_mode_scroll || (r_slot == c_LAST_SLOT));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (i_load_start) begin
      w_state_next = c_FETCH;
    end else begin
      case (r_state)
        c_IDLE:  if (w_start_scroll) w_state_next = c_FETCH;
        c_FETCH: w_state_next = c_READ;
        c_READ:  w_state_next = c_WRITE;
        c_WRITE: w_state_next = w_last_tile ? c_DONE : c_FETCH;
        c_DONE:  w_state_next = c_IDLE;
        default: w_state_next = c_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_change_id = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      c_IDLE:  w_busy      = 1'b0;
      c_WRITE: w_change_id = 1'b1;
      c_DONE:  w_done      = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Tile walker, ROM address and grid write registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_row         <= 4'd0;
      r_slot        <= 5'd0;
      r_col         <= 8'd0;
      r_mode_scroll <= 1'b0;
      r_rom_addr    <= 12'd0;
      r_grid_row    <= 4'd0;
      r_grid_col    <= 5'd0;
      r_block_id    <= 4'd0;
      r_head_slot   <= 5'd0;
      r_scroll_col  <= 8'd0;
    end else if (i_load_start) begin
      r_mode_scroll <= 1'b0;
      r_row         <= 4'd0;
      r_slot        <= 5'd0;
      r_col         <= w_c0;
      r_rom_addr    <= {w_c0, 4'd0};
      r_scroll_col  <= w_c0;
      r_head_slot   <= 5'd0;
    end else if (w_start_scroll) begin
      // The new column lands in the slot that is about to scroll off-screen.
      r_mode_scroll <= 1'b1;
      r_row         <= 4'd0;
      r_slot        <= r_head_slot;
      r_col         <= w_scroll_load_col;
      r_rom_addr    <= {w_scroll_load_col, 4'd0};
    end else if (r_state == c_READ) begin
      // ROM data for the address presented in FETCH is valid now.
      r_grid_row <= r_row;
      r_grid_col <= r_slot;
      r_block_id <= i_rom_data;
    end else if (r_state == c_WRITE) begin
      if (!w_last_tile) begin
        // The address for the next tile is ready as FETCH begins.
        if (r_row == c_LAST_ROW) begin
          r_row      <= 4'd0;
          r_col      <= r_col + 8'd1;
          r_slot     <= r_slot + 5'd1;
          r_rom_addr <= {r_col + 8'd1, 4'd0};
        end else begin
          r_row      <= r_row + 4'd1;
          r_rom_addr <= {r_col, r_row + 4'd1};
        end
      end else if (r_mode_scroll) begin
        // Advance the view so it is already current while o_done is high.
        r_head_slot  <= (r_head_slot == c_LAST_SLOT) ? 5'd0 : r_head_slot + 5'd1;
        r_scroll_col <= r_scroll_col + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scroll request queue (depth one) and drop indication
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pending     <= 1'b0;
      r_scroll_drop <= 1'b0;
    end else begin
      r_scroll_drop <= 1'b0;
      if (i_load_start) begin
        r_pending     <= 1'b0;
        r_scroll_drop <= i_scroll_step;
      end else if (r_state == c_IDLE) begin
        // A queued step is consumed here whether or not at_end refuses it;
        // a new step arriving alongside it has nowhere to go.
        r_pending <= 1'b0;
        if (r_pending && i_scroll_step) begin
          r_scroll_drop <= 1'b1;
        end
      end else if (i_scroll_step) begin
        if (r_pending) begin
          r_scroll_drop <= 1'b1;
        end else begin
          r_pending <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_rom_addr     = r_rom_addr;
  assign o_grid_row     = r_grid_row;
  assign o_grid_col     = r_grid_col;
  assign o_new_block_id = r_block_id;
  assign o_change_id    = w_change_id;
  assign o_head_slot    = r_head_slot;
  assign o_scroll_col   = r_scroll_col;
  assign o_busy         = w_busy;
  assign o_done         = w_done;
  assign o_at_end       = w_at_end;
  assign o_scroll_drop  = r_scroll_drop;

endmodule
`default_nettype wire

// File: doc/level_column_loader.md
Name: level_column_loader

Overview:
- Upstream feeder for the on-screen block grid. It reads 4-bit block IDs from the synchronous level ROM and writes them one tile per strobe into the per-tile block registers: grid_row/grid_col select the tile, change_id is the write enable and new_block_id is the data.
- It supports two operations:
  - Full-screen load: at level start or respawn.
  - Single-column load: when the camera scrolls one tile right.
- The grid is a circular buffer of columns, so scrolling rewrites only one column.

Parameters:
- ROWS, 15, tile rows on screen (480/32).
- COLS, 20, tile columns on screen (640/32).
- LEVEL_COLS, 224, total level width in tiles (max 256).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- load_start  in  1  pulse; start full-screen load at level column start_col
- start_col  in  8  first level column for a full load
- scroll_step  in  1  pulse; load the next column on the right
- rom_addr  out  12  level ROM address = {level_col[7:0], row[3:0]}
- rom_data  in  4  ROM block ID; valid the cycle after rom_addr is presented
- grid_row  out  4  target tile row
- grid_col  out  5  target tile slot (0..COLS-1)
- new_block_id  out  4  block ID to write
- change_id  out  1  one-cycle write strobe for tile (grid_row, grid_col)
- head_slot  out  5  grid slot holding the leftmost visible level column
- scroll_col  out  8  level column shown in head_slot
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when an operation completes
- at_end  out  1  scroll_col + COLS >= LEVEL_COLS
- scroll_drop  out  1  one-cycle pulse when a scroll_step is discarded

Behaviour:
- Reset:
  - All registered outputs go to 0: rom_addr, grid_row, grid_col, new_block_id, change_id, head_slot, scroll_col, busy, done, scroll_drop.
  - pending flag cleared; state = IDLE.
  - Reset asserted mid-operation aborts immediately, and change_id is 0 from the next cycle.
- FSM states:
  - IDLE, FETCH, READ, WRITE, DONE.
  - Per tile: FETCH drives rom_addr; READ samples rom_data at the end of the cycle; WRITE holds change_id=1 with registered grid_row, grid_col and new_block_id. That is 3 cycles per tile.
  - change_id is high only in WRITE.
- Full load:
  - Triggered by load_start in any state. It aborts any current operation and clears pending.
  - Latched column: c0 = min(start_col, LEVEL_COLS-COLS).
  - Sets scroll_col=c0 and head_slot=0.
  - Tile order: row-major within a column (row 0..ROWS-1), columns i=0..COLS-1. Level column = c0+i, slot = i.
  - If load_start is sampled at edge E0, the first change_id is in the 3rd cycle after E0.
  - ROWS*COLS = 300 writes; done pulses in the cycle after the last WRITE (DONE state), then IDLE.
- Scroll step:
  - Accepted in IDLE when at_end=0.
  - Loads level column scroll_col+COLS into slot head_slot, ROWS writes (45 cycles).
  - In the DONE cycle: head_slot = (head_slot+1) mod COLS (wraps 19→0) and scroll_col += 1. done pulses.
  - With at_end=1, the step is ignored: no writes, no done, no scroll_drop.
- Simultaneous events:
  - load_start and scroll_step in the same cycle: load_start wins; the scroll is dropped and scroll_drop pulses.
  - scroll_step while busy with a scroll: sets pending. It is serviced from IDLE on the cycle after DONE, with at_end re-evaluated.
  - A further scroll_step while pending=1 is discarded with a scroll_drop pulse.
  - scroll_step during a full load: sets pending, same rules.
- Width rules:
  - Level-column arithmetic is 8-bit; clamping guarantees no overflow.
  - rom_addr row field 15 is never generated.

Test Plan:
- Full load, start_col=0. ROM model data = (col+row)&0xF → exactly 300 change_id pulses, one every 3 cycles. First pulse is 3 cycles after load_start, with (row0, col0, id0). Last pulse is (14,19,id=(19+14)&0xF=1). done is 1 cycle after the last pulse. head_slot=0, scroll_col=0.
- scroll_step after the load → 15 writes to slot 0 with level column 20. rom_addr 0x140..0x14E. Then head_slot=1, scroll_col=1, done=1 for one cycle.
- 20 successive scrolls → slot wraps: the 20th writes slot 19, and head_slot becomes 0 with scroll_col=20.
- load_start with start_col=250 → clamped c0=204; at_end=1. A following scroll_step produces no writes and no done.
- Two scroll_steps issued mid-scroll, then a third → first pending and serviced immediately after DONE; the third gives scroll_drop=1. Net scroll_col += 2.
- Reset asserted during a full load (tile 100) → the next cycle has change_id=0, busy=0 and all outputs 0. A subsequent load_start behaves as in the first scenario.
